tx_lane_sequencer: RTL and testbench

- Transmit-side controller that sequences the 8-bit symbol stream fed to the 8b/10b encoder and serializer.
- Accepts 8/16/32-bit words over a valid/ready handshake, with the width selected by dataS, and splits them into bytes, LSB first.
- Drives K and TxElecIdle, and handles link bring-up training, idle fill and periodic SKP ordered-set insertion.
- Sits between the transmit data source and the encoder in the clkTx domain.

---
 rtl/tx_seq_pkg.sv | 33 +++
 rtl/skp_timer.sv | 32 +++
 rtl/tx_lane_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_tx_lane_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/tx_seq_pkg.sv
// Shared symbol constants, state encoding and width decode for the
// transmit lane sequencer.
package tx_seq_pkg;

  localparam logic [7:0] SYM_COM   = 8'hBC;  // K28.5: training, idle fill, SKP head
  localparam logic [7:0] SYM_SKP   = 8'h1C;  // K28.0: SKP body
  localparam logic [7:0] SYM_IDLE0 = 8'h00;  // driven while electrically idle

  typedef enum logic [2:0] {
    ELEC_IDLE,
    TRAIN,
    IDLE,
    SEND,
    SKP
  } state_t;

  typedef enum logic [1:0] {
    WIDTH_8   = 2'b00,
    WIDTH_16  = 2'b01,
    WIDTH_32  = 2'b10,
    WIDTH_32R = 2'b11   // reserved code, behaves as 32-bit
  } width_t;

  // Number of bytes carried by a word of the given width code.
  function automatic logic [2:0] nbytes(input logic [1:0] data_s);
    case (width_t'(data_s))
      WIDTH_8:  nbytes = 3'd1;
      WIDTH_16: nbytes = 3'd2;
      default:  nbytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/skp_timer.sv
// Saturating symbol counter that raises a pending flag once SKP_INTERVAL
// symbols have gone out since the last SKP ordered set.
module skp_timer #(
  parameter int SKP_INTERVAL = 118
) (
  input  logic clkTx,
  input  logic rst,
  input  logic i_strobe,   // one symbol loaded this edge
  input  logic i_hold,     // freeze the count (link not carrying traffic)
  input  logic i_clear,    // restart the interval
  output logic o_pending
);

  localparam logic [9:0] CNT_MAX = 10'(SKP_INTERVAL);

  logic [9:0] r_count;

  // Count symbols up to the interval and stick there until cleared.
  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clkTx or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (!i_hold && i_strobe && (r_count != CNT_MAX)) begin
      r_count <= r_count + 10'd1;
    end
  end

  assign o_pending = (r_count == CNT_MAX);

endmodule

// File: rtl/tx_lane_sequencer.sv
// Transmit lane sequencer: brings the link out of electrical idle with a
// COM training burst, then serialises 8/16/32-bit words LSB-first onto the
// 8-bit symbol stream, filling with COM and inserting SKP sets on word
// boundaries.
module tx_lane_sequencer
  import tx_seq_pkg::*;
#(
  parameter int TRAIN_LEN    = 16,
  parameter int SKP_INTERVAL = 118
) (
  input  logic        clkTx,
  input  logic        rst,
  input  logic        enb,
  input  logic [1:0]  dataS,
  input  logic [31:0] dataIn,
  input  logic        inValid,
  output logic        inReady,
  output logic [7:0]  dataOut8,
  output logic        K,
  output logic        TxElecIdle,
  output logic        skpBusy
);

  localparam int            TW         = (TRAIN_LEN > 1) ? $clog2(TRAIN_LEN) : 1;
  localparam logic [TW-1:0] TRAIN_LAST = TW'(TRAIN_LEN - 1);

  state_t        r_state;
  logic [TW-1:0] r_train_cnt;
  logic [31:0]   r_word;
  logic [2:0]    r_nbytes;
  logic [1:0]    r_byte_idx;
  logic [1:0]    r_skp_idx;
  logic [7:0]    r_data_out;
  logic          r_k;
  logic          r_elec_idle;
  logic          r_skp_busy;

  logic          w_pending;
  logic          w_ready;
  logic          w_accept;
  logic          w_last_byte;
  logic [7:0]    w_cur_byte;
  logic          w_strobe;
  logic          w_hold;
  logic          w_clear;

  assign w_last_byte = ({1'b0, r_byte_idx} == (r_nbytes - 3'd1));
  assign w_cur_byte  = r_word[{r_byte_idx, 3'b000} +: 8];

  // Offer a new word in idle, or on the last byte of the current word so
  // back-to-back words run without a fill symbol; a pending SKP blocks it.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_ready = 1'b0;
    case (r_state)
      IDLE:    w_ready = enb & ~w_pending;
      SEND:    w_ready = w_last_byte & enb & ~w_pending;
      default: w_ready = 1'b0;
    endcase
  end

  assign w_accept = inValid & w_ready;
  assign inReady  = w_ready;

  // Symbols count only once the link carries traffic; the interval restarts
  // when an SKP set starts or the link drops back to electrical idle.
  assign w_hold   = (r_state == ELEC_IDLE) | (r_state == TRAIN);
  assign w_strobe = (r_state == IDLE) | (r_state == SEND) | (r_state == SKP);
  assign w_clear  = ((r_state == IDLE) & (~enb | w_pending)) |
                    ((r_state == SKP) & (r_skp_idx == 2'd3) & ~enb);

  skp_timer #(
    .SKP_INTERVAL(SKP_INTERVAL)
  ) u_skp_timer (
    .clkTx     (clkTx),
    .rst       (rst),
    .i_strobe  (w_strobe),
    .i_hold    (w_hold),
    .i_clear   (w_clear),
    .o_pending (w_pending)
  );

  // Lane state machine; each edge loads the symbol for the coming cycle.
  always_ff @(posedge clkTx or negedge rst) begin
    if (!rst) begin
      r_state     <= ELEC_IDLE;
      r_train_cnt <= '0;
      r_word      <= '0;
      r_nbytes    <= 3'd1;
      r_byte_idx  <= '0;
      r_skp_idx   <= '0;
      r_data_out  <= SYM_IDLE0;
      r_k         <= 1'b0;
      r_elec_idle <= 1'b1;
      r_skp_busy  <= 1'b0;
    end else begin
      case (r_state)
        ELEC_IDLE: begin
          r_data_out  <= SYM_IDLE0;
          r_k         <= 1'b0;
          r_elec_idle <= 1'b1;
          r_skp_busy  <= 1'b0;
          if (enb) begin
            r_state     <= TRAIN;
            r_train_cnt <= '0;
            r_data_out  <= SYM_COM;
            r_k         <= 1'b1;
            r_elec_idle <= 1'b0;
          end
        end

        TRAIN: begin
          r_data_out <= SYM_COM;
          r_k        <= 1'b1;
          if (r_train_cnt == TRAIN_LAST) begin
            r_state <= IDLE;
          end else begin
            r_train_cnt <= r_train_cnt + TW'(1);
          end
        end

        IDLE: begin
          if (!enb) begin
            r_state     <= ELEC_IDLE;
            r_data_out  <= SYM_IDLE0;
            r_k         <= 1'b0;
            r_elec_idle <= 1'b1;
          end else if (w_pending) begin
            r_state    <= SKP;
            r_skp_idx  <= '0;
            r_data_out <= SYM_COM;
            r_k        <= 1'b1;
            r_skp_busy <= 1'b1;
          end else begin
            r_data_out <= SYM_COM;
            r_k        <= 1'b1;
            if (w_accept) begin
              r_state    <= SEND;
              r_word     <= dataIn;
              r_nbytes   <= nbytes(dataS);
              r_byte_idx <= '0;
            end
          end
        end

        SEND: begin
          r_data_out <= w_cur_byte;
          r_k        <= 1'b0;
          if (w_last_byte) begin
            if (w_accept) begin
              r_word     <= dataIn;
              r_nbytes   <= nbytes(dataS);
              r_byte_idx <= '0;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_byte_idx <= r_byte_idx + 2'd1;
          end
        end

        SKP: begin
          if (r_skp_idx == 2'd3) begin
            r_skp_busy <= 1'b0;
            if (!enb) begin
              r_state     <= ELEC_IDLE;
              r_data_out  <= SYM_IDLE0;
              r_k         <= 1'b0;
              r_elec_idle <= 1'b1;
            end else begin
              r_state    <= IDLE;
              r_data_out <= SYM_COM;
              r_k        <= 1'b1;
            end
          end else begin
            r_skp_idx  <= r_skp_idx + 2'd1;
            r_data_out <= SYM_SKP;
            r_k        <= 1'b1;
            r_skp_busy <= 1'b1;
          end
        end

        default: r_state <= ELEC_IDLE;
      endcase
    end
  end

  assign dataOut8   = r_data_out;
  assign K          = r_k;
  assign TxElecIdle = r_elec_idle;
  assign skpBusy    = r_skp_busy;

endmodule

// File: tb/tb_tx_lane_sequencer.sv
// Directed bench for tx_lane_sequencer: training, single/back-to-back words,
// SKP insertion on a short interval, enable drop mid-word, async reset.
module tb_tx_lane_sequencer;

  logic        clkTx;
  logic        rst;
  logic        enb;
  logic [1:0]  dataS;
  logic [31:0] dataIn;
  logic        inValid;

  logic        inReady;
  logic [7:0]  dataOut8;
  logic        K;
  logic        TxElecIdle;
  logic        skpBusy;

  logic        s_ready;
  logic [7:0]  s_dout;
  logic        s_k;
  logic        s_ei;
  logic        s_busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected dut_s stream for edges E17..E32 with 32-bit words held valid.
  logic [7:0] skp_sym   [16] = '{8'hBC, 8'h6F, 8'h45, 8'h23, 8'h01, 8'h6F, 8'h45, 8'h23,
                                 8'h01, 8'hBC, 8'h1C, 8'h1C, 8'h1C, 8'hBC, 8'hBC, 8'h6F};
  logic       skp_k     [16] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic       skp_busy  [16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic       skp_ready [16] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  tx_lane_sequencer #(
    .TRAIN_LEN    (16),
    .SKP_INTERVAL (118)
  ) dut (
    .clkTx      (clkTx),
    .rst        (rst),
    .enb        (enb),
    .dataS      (dataS),
    .dataIn     (dataIn),
    .inValid    (inValid),
    .inReady    (inReady),
    .dataOut8   (dataOut8),
    .K          (K),
    .TxElecIdle (TxElecIdle),
    .skpBusy    (skpBusy)
  );

  tx_lane_sequencer #(
    .TRAIN_LEN    (16),
    .SKP_INTERVAL (8)
  ) dut_s (
    .clkTx      (clkTx),
    .rst        (rst),
    .enb        (enb),
    .dataS      (dataS),
    .dataIn     (dataIn),
    .inValid    (inValid),
    .inReady    (s_ready),
    .dataOut8   (s_dout),
    .K          (s_k),
    .TxElecIdle (s_ei),
    .skpBusy    (s_busy)
  );

  initial clkTx = 1'b0;
  always #5 clkTx = ~clkTx;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clkTx);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [7:0] sym, input logic k,
                            input logic ready);
    check({tag, "_sym"},   32'(dataOut8), 32'(sym));
    check({tag, "_k"},     32'(K),        32'(k));
    check({tag, "_ready"}, 32'(inReady),  32'(ready));
  endtask

  // Reset both lanes, enable, and walk the full 16-symbol training burst.
  task automatic reset_and_train();
    enb     = 1'b0;
    inValid = 1'b0;
    dataS   = 2'b00;
    dataIn  = '0;
    rst     = 1'b0;
    #1;
    expect_out("rst", 8'h00, 1'b0, 1'b0);
    check("rst_ei",   32'(TxElecIdle), 32'd1);
    check("rst_busy", 32'(skpBusy),    32'd0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("eidle_ei", 32'(TxElecIdle), 32'd1);
    expect_out("eidle", 8'h00, 1'b0, 1'b0);
    enb = 1'b1;
    tick();
    check("train_start_ei", 32'(TxElecIdle), 32'd0);
    expect_out("train_0", 8'hBC, 1'b1, 1'b0);
    for (int i = 1; i < 16; i++) begin
      tick();
      expect_out($sformatf("train_%0d", i), 8'hBC, 1'b1, 1'b0);
    end
    tick();
    expect_out("idle_fill", 8'hBC, 1'b1, 1'b1);
    check("idle_ei", 32'(TxElecIdle), 32'd0);
  endtask

  initial begin
    rst     = 1'b1;
    enb     = 1'b0;
    dataS   = 2'b00;
    dataIn  = '0;
    inValid = 1'b0;
    #2;

    // Training after reset.
    reset_and_train();

    // Single 8-bit word.
    dataS   = 2'b00;
    dataIn  = 32'h0000_00CC;
    inValid = 1'b1;
    tick();
    inValid = 1'b0;
    dataIn  = 32'hDEAD_BEEF;
    expect_out("b8_accept", 8'hBC, 1'b1, 1'b1);
    tick();
    expect_out("b8_byte0", 8'hCC, 1'b0, 1'b1);
    tick();
    expect_out("b8_fill", 8'hBC, 1'b1, 1'b1);

    // Two 16-bit words back-to-back, then data changes that must be ignored.
    reset_and_train();
    dataS   = 2'b01;
    dataIn  = 32'h0000_ABCD;
    inValid = 1'b1;
    tick();
    expect_out("w16_accept", 8'hBC, 1'b1, 1'b0);
    tick();
    expect_out("w16_a_b0", 8'hCD, 1'b0, 1'b1);
    tick();
    inValid = 1'b0;
    dataIn  = 32'h0000_FFFF;
    expect_out("w16_a_b1", 8'hAB, 1'b0, 1'b0);
    tick();
    expect_out("w16_b_b0", 8'hCD, 1'b0, 1'b1);
    tick();
    expect_out("w16_b_b1", 8'hAB, 1'b0, 1'b1);
    tick();
    expect_out("w16_fill", 8'hBC, 1'b1, 1'b1);

    // Continuous 32-bit words on the short-interval lane: SKP on a boundary.
    reset_and_train();
    dataS   = 2'b10;
    dataIn  = 32'h0123_456F;
    inValid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      check($sformatf("skp_%0d_sym", i),   32'(s_dout),  32'(skp_sym[i]));
      check($sformatf("skp_%0d_k", i),     32'(s_k),     32'(skp_k[i]));
      check($sformatf("skp_%0d_busy", i),  32'(s_busy),  32'(skp_busy[i]));
      check($sformatf("skp_%0d_ready", i), 32'(s_ready), 32'(skp_ready[i]));
    end
    check("skp_ei", 32'(s_ei), 32'd0);
    inValid = 1'b0;

    // Enable dropped mid-word: word completes, then electrical idle.
    reset_and_train();
    dataS   = 2'b10;
    dataIn  = 32'h0123_456F;
    inValid = 1'b1;
    tick();
    inValid = 1'b0;
    tick();
    expect_out("enb_b0", 8'h6F, 1'b0, 1'b0);
    tick();
    expect_out("enb_b1", 8'h45, 1'b0, 1'b0);
    enb = 1'b0;
    tick();
    expect_out("enb_b2", 8'h23, 1'b0, 1'b0);
    tick();
    expect_out("enb_b3", 8'h01, 1'b0, 1'b0);
    check("enb_b3_ei", 32'(TxElecIdle), 32'd0);
    tick();
    expect_out("enb_eidle", 8'h00, 1'b0, 1'b0);
    check("enb_eidle_ei", 32'(TxElecIdle), 32'd1);

    // Async reset mid-word, then the full training sequence again.
    reset_and_train();
    dataS   = 2'b10;
    dataIn  = 32'h0123_456F;
    inValid = 1'b1;
    tick();
    inValid = 1'b0;
    tick();
    tick();
    expect_out("arst_b1", 8'h45, 1'b0, 1'b0);
    #3;
    rst = 1'b0;
    #1;
    expect_out("arst_now", 8'h00, 1'b0, 1'b0);
    check("arst_now_ei",   32'(TxElecIdle), 32'd1);
    check("arst_now_busy", 32'(skpBusy),    32'd0);
    reset_and_train();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1);
  end

endmodule
